// File: rtl/domain_reset_pkg.sv
// -----------------------------------------------------------------------------
// domain_reset_pkg
// Shared definitions for the per-domain reset receiver:
//   - state_t         : FSM state encoding (S_SYNC, S_HOLD, S_RUN)
//   - DEF_SYNC_STAGES : default synchronizer depth
//   - DEF_HOLD_CYCLES : default post-sync hold length in cycles
//   - cnt_width()     : width of the hold counter for a given hold length
// -----------------------------------------------------------------------------
package domain_reset_pkg;

    typedef enum logic [1:0] {
        S_SYNC = 2'd0,
        S_HOLD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    localparam int DEF_SYNC_STAGES = 32'sd2;
    localparam int DEF_HOLD_CYCLES = 32'sd16;

    // Counter only has to reach hold_cycles-1, sized with one spare value so
    // the terminal compare always happens before any overflow.
    function automatic int cnt_width(input int hold_cycles);
        return $clog2(hold_cycles + 32'sd1);
    endfunction

endpackage

// File: rtl/reset_sync_chain.sv
// -----------------------------------------------------------------------------
// reset_sync_chain
// Async-set shift chain used to re-time the deassertion of a reset into the
// local clock domain. Assertion is immediate (all stages set), deassertion
// ripples through STAGES flops.
// Ports:
//   clk      : domain clock
//   rst      : asynchronous active-high reset to be synchronized
//   sync_out : last stage, high while the re-timed reset is still asserted
// -----------------------------------------------------------------------------
module reset_sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    output logic sync_out
);

    logic [STAGES-1:0] chain_r;

    // Shift zeros in from stage 0; rst sets every stage at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_r <= {STAGES{1'b1}};
        end else begin
            chain_r <= {chain_r[STAGES-2:0], 1'b0};
        end
    end

    assign sync_out = chain_r[STAGES-1];

endmodule

// File: rtl/domain_reset.sv
// -----------------------------------------------------------------------------
// domain_reset
// Per-domain reset receiver. Re-times the release of the system reset into
// clk, stretches it by HOLD_CYCLES, then releases a glitch-free rst_out.
// Optional software reset handshake is enabled by defining the macro
// DOMAIN_RESET_SOFT_EN; without it soft_req is ignored and soft_ack stays 0.
// Parameters:
//   SYNC_STAGES : synchronizer depth (2..4)
//   HOLD_CYCLES : hold length after synchronized release (1..255)
// Ports:
//   clk      : domain clock
//   rst      : system reset, asynchronous, active-high
//   soft_req : software reset request, level-sampled in S_RUN
//   rst_out  : domain reset, async assert / sync deassert
//   soft_ack : one-cycle pulse when a soft reset completes
//   done     : one-cycle pulse on every release of rst_out
//   busy     : high in every state except S_RUN
// -----------------------------------------------------------------------------
module domain_reset
    import domain_reset_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic soft_req,
    output logic rst_out,
    output logic soft_ack,
    output logic done,
    output logic busy
);

    localparam int CNT_W = cnt_width(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 32'sd1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'sd1);

    state_t            state_r;
    state_t            state_nxt_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_nxt_s;
    logic              soft_pend_r;
    logic              soft_pend_nxt_s;
    logic              sync_rst_s;
    logic              soft_go_s;
    logic              release_s;
    logic              rst_out_r;
    logic              busy_r;
    logic              done_r;
    logic              soft_ack_r;

    reset_sync_chain #(
        .STAGES   (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .sync_out (sync_rst_s)
    );

`ifdef DOMAIN_RESET_SOFT_EN
    assign soft_go_s = soft_req;
`else
    logic soft_req_unused_s;
    assign soft_req_unused_s = soft_req;
    assign soft_go_s         = 1'b0;
`endif

    // Next-state, counter and soft-reset bookkeeping.
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r;
        soft_pend_nxt_s = soft_pend_r;
        case (state_r)
            S_SYNC: begin
                if (!sync_rst_s) begin
                    state_nxt_s     = S_HOLD;
                    cnt_nxt_s       = '0;
                    soft_pend_nxt_s = 1'b0;
                end else begin
                    state_nxt_s     = S_SYNC;
                end
            end
            S_HOLD: begin
                if (cnt_r == CNT_LAST) begin
                    state_nxt_s     = S_RUN;
                    cnt_nxt_s       = '0;
                    soft_pend_nxt_s = 1'b0;
                end else begin
                    cnt_nxt_s       = cnt_r + CNT_ONE;
                end
            end
            S_RUN: begin
                // Soft reset re-enters the hold phase directly; the
                // synchronizer is untouched because rst never moved.
                if (soft_go_s) begin
                    state_nxt_s     = S_HOLD;
                    cnt_nxt_s       = '0;
                    soft_pend_nxt_s = 1'b1;
                end else begin
                    state_nxt_s     = S_RUN;
                end
            end
            default: begin
                state_nxt_s     = S_SYNC;
                cnt_nxt_s       = '0;
                soft_pend_nxt_s = 1'b0;
            end
        endcase
    end

    assign release_s = (state_r == S_HOLD) && (state_nxt_s == S_RUN);

    // State, counter and output registers; outputs are registered from the
    // next state so rst_out has no combinational path from soft_req.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= S_SYNC;
            cnt_r       <= '0;
            soft_pend_r <= 1'b0;
            rst_out_r   <= 1'b1;
            busy_r      <= 1'b1;
            done_r      <= 1'b0;
            soft_ack_r  <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            soft_pend_r <= soft_pend_nxt_s;
            rst_out_r   <= (state_nxt_s != S_RUN);
            busy_r      <= (state_nxt_s != S_RUN);
            done_r      <= release_s;
            soft_ack_r  <= release_s & soft_pend_r;
        end
    end

    assign rst_out  = rst_out_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign soft_ack = soft_ack_r;

endmodule

// File: tb/tb_domain_reset.sv
// -----------------------------------------------------------------------------
// tb_domain_reset
// Self-checking bench for domain_reset. A reference model counts edges left
// until release (SYNC_STAGES+1+HOLD_CYCLES after rst, HOLD_CYCLES after a
// soft request) and predicts every output after every clock edge and after
// each asynchronous rst pulse.
// -----------------------------------------------------------------------------
module tb_domain_reset;

    localparam int SYNC = 2;
    localparam int HOLD = 16;
`ifdef DOMAIN_RESET_SOFT_EN
    localparam bit SOFT_EN = 1'b1;
`else
    localparam bit SOFT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic soft_req;
    logic rst_out;
    logic soft_ack;
    logic done;
    logic busy;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit m_run;
    int m_left;
    bit m_soft;
    bit e_done;
    bit e_ack;

    domain_reset #(
        .SYNC_STAGES (SYNC),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .soft_req (soft_req),
        .rst_out  (rst_out),
        .soft_ack (soft_ack),
        .done     (done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".rst_out"},  rst_out,  !m_run);
        chk({tag, ".busy"},     busy,     !m_run);
        chk({tag, ".done"},     done,     e_done);
        chk({tag, ".soft_ack"}, soft_ack, e_ack);
    endtask

    // rst asserted: everything restarts, the count begins after rst falls.
    task automatic model_async();
        m_run  = 1'b0;
        m_left = SYNC + 1 + HOLD;
        m_soft = 1'b0;
        e_done = 1'b0;
        e_ack  = 1'b0;
    endtask

    task automatic model_edge();
        if (rst) begin
            model_async();
        end else begin
            e_done = 1'b0;
            e_ack  = 1'b0;
            if (m_run) begin
                if (SOFT_EN && soft_req) begin
                    m_run  = 1'b0;
                    m_left = HOLD;
                    m_soft = 1'b1;
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_run  = 1'b1;
                    e_done = 1'b1;
                    e_ack  = m_soft;
                    m_soft = 1'b0;
                end
            end
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        chk_all(tag);
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    // Sub-cycle rst pulse; called 1 ns after an edge, so it ends well before
    // the next one. rst_out must already be high while rst is still high.
    task automatic pulse_rst(input string tag);
        rst = 1'b1;
        model_async();
        #1;
        chk_all(tag);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        soft_req = 1'b0;
        model_async();
        #1;
        chk_all("reset_state");

        // Power-on: rst high for three edges, released mid-cycle.
        run("por_hold", 3);
        rst = 1'b0;
        run("por_release", 25);

        // Asynchronous abort while running.
        pulse_rst("async_assert");
        run("async_recover", 25);

        // Single-cycle soft request.
        soft_req = 1'b1;
        step("soft_pulse");
        soft_req = 1'b0;
        run("soft_run", 25);

        // Soft request held through SYNC/HOLD after a restart.
        pulse_rst("soft_ign_rst");
        soft_req = 1'b1;
        run("soft_ignored", 40);
        soft_req = 1'b0;
        run("soft_ign_tail", 25);

        // rst during a soft-reset hold: no soft_ack, full restart.
        soft_req = 1'b1;
        step("soft_then_rst");
        soft_req = 1'b0;
        run("soft_hold", 5);
        pulse_rst("rst_in_soft");
        run("rst_in_soft_rec", 25);

        // Toggle soft_req every cycle while running.
        for (int i = 0; i < 100; i++) begin
            soft_req = ~soft_req;
            step("toggle");
        end
        soft_req = 1'b0;
        run("toggle_tail", 25);

        // Randomized requests and occasional rst pulses.
        for (int i = 0; i < 400; i++) begin
            soft_req = ($urandom_range(0, 7) == 0);
            step("random");
            if ($urandom_range(0, 59) == 0) pulse_rst("random_rst");
        end
        soft_req = 1'b0;
        run("final", 25);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
